// File: rtl/cache_mem_responder.sv
// cache_mem_responder: fixed-latency line memory answering cache memory-side requests
module cache_mem_responder #(
  parameter int LATENCY        = 8,
  parameter int DEPTH          = 256,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  output logic [MEM_DATA_WIDTH-1:0] mem_rdata,
  output logic                      mem_ready,
  output logic                      proto_err
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                    state, nxt;
  logic [7:0]                cnt;
  logic [MEM_ADDR_WIDTH-1:0] a_q;
  logic                      w_q;
  logic [MEM_DATA_WIDTH-1:0] d_q;
  logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];
  logic                      start, fire, f_w, viol;
  logic [IW-1:0]             f_idx;
  logic [MEM_DATA_WIDTH-1:0] f_d;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: a latency of one skips BUSY entirely
  always_comb
    nxt = state == IDLE ? (start ? (LATENCY == 1 ? RESP : BUSY) : IDLE) :
          state == BUSY ? (cnt == 8'd1 ? RESP : BUSY) : IDLE;
  // access selection and handshake checking; on accept the live inputs stand in for the latches
  always_comb begin
    start = state == IDLE && (mem_read || mem_write);
    fire  = nxt == RESP;
    f_w   = start ? mem_write : w_q;
    f_idx = start ? mem_addr[IW-1:0] : a_q[IW-1:0];
    f_d   = start ? mem_wdata : d_q;
    viol  = state != IDLE &&
            ((w_q ? (!mem_write || mem_read || mem_wdata != d_q) : (!mem_read || mem_write)) ||
             mem_addr != a_q);
  end
  // request latches, latency counter and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      a_q       <= '0;
      w_q       <= 1'b0;
      d_q       <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      if (start) begin
        a_q <= mem_addr;
        w_q <= mem_write;
        d_q <= mem_wdata;
        cnt <= 8'(LATENCY - 1);
      end else if (state == BUSY) cnt <= cnt - 8'd1;
      mem_ready <= fire;
      if (fire && !f_w) mem_rdata <= mem[f_idx];
      if ((start && mem_read && mem_write) || viol) proto_err <= 1'b1;
    end
  // line storage, unreset; the rst_n gate keeps a request held through reset from committing
  always_ff @(posedge clk)
    if (rst_n && fire && f_w) mem[f_idx] <= f_d;
endmodule
